e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit, directly downstream of the D→E pipeline register. It consumes the decoded MDU operation and forwarded rs/rt operands for the instruction currently in E. It models MIPS HI/LO with fixed-latency MULT/MULTU (5 cycles) and DIV/DIVU (10 cycles), and drives a busy flag that the D-stage stall logic uses. An exception/interrupt request (`req`) suppresses the E-stage instruction's side effects on HI/LO.

## Interface
Parameters:
- MUL_CYCLES, 5, busy length of MULT/MULTU
- DIV_CYCLES, 10, busy length of DIV/DIVU

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req  in  1  CP0 exception/interrupt request for the instruction now in E; high = squash its MDU effect
- mdu_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others = NONE
- rs_d  in  32  forwarded rs value (dividend/multiplicand, MTHI/MTLO source)
- rt_d  in  32  forwarded rt value (divisor/multiplier)
- start  out  1  combinational: mdu_op ∈ {1..4} & ~req & ~busy
- busy  out  1  registered: operation in flight
- hi  out  32  committed HI
- lo  out  32  committed LO
- mdu_rd  out  32  combinational: hi if MFHI, lo if MFLO, else 0

## Operation
- Internal state: hi, lo, cnt (4 bits), pend_hi, pend_lo (32 each).
- `busy = (cnt != 0)`.
- Start:
  - On the edge where start = 1, compute the full result from rs_d/rt_d into pend_hi/pend_lo.
  - cnt ← MUL_CYCLES for ops 1/2, DIV_CYCLES for ops 3/4.
- Count:
  - Each edge with cnt > 1: cnt ← cnt − 1.
  - Edge with cnt == 1: hi ← pend_hi, lo ← pend_lo, cnt ← 0.
- MULT: signed 32×32→64; hi = [63:32], lo = [31:0]. MULTU: unsigned.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (rt_d == 0, ops 3/4):
  - Timing is normal (busy for DIV_CYCLES).
  - No commit: hi/lo remain unchanged at completion.
- MTHI/MTLO:
  - When ~req & ~busy, hi/lo ← rs_d on that edge; no busy cycle.
  - Ignored while busy.
- MFHI/MFLO: pure combinational read of committed hi/lo; no state change.
- Start or MT* while busy is ignored: no restart, no operand capture. The D-stage stall normally prevents this.
- req = 1:
  - Blocks start and MTHI/MTLO for the current mdu_op.
  - An operation already in flight (started on an earlier edge) continues and commits normally.
- Reset (asynchronous, low): hi, lo, pend_hi, pend_lo, cnt ← 0, so busy ← 0.
  - An in-flight operation is discarded without commit.
- Reset values: busy 0, hi 0, lo 0.
  - mdu_rd 0 unless mdu_op selects MFHI/MFLO; it then shows 0 because hi/lo are 0.
  - start follows mdu_op & ~req.

## Timing
- MULT accepted at edge k:
  - busy high for the cycles after edges k … k+4 (5 cycles).
  - hi/lo updated at edge k+5; busy low after edge k+5.
- DIV accepted at edge k: busy for 10 cycles; commit at edge k+10.
- Stall rule for D stage: stall any MDU-class instruction in D while start | busy.
- Back-to-back: a new op may start on the same edge as the commit, provided busy was sampled low in that cycle.
  - Because busy is still high during the commit cycle, the earliest new start is edge k+6 after a MULT at k.
- MTHI at edge j: hi visible on `hi` and via MFHI from cycle j+1.
- start and mdu_rd have zero latency (combinational). busy, hi and lo are registered outputs.

## Test plan
- Reset mid-op: MULT 3×4 at edge 0, reset low in cycle 2 → busy 0 immediately; hi = lo = 0; no commit at edge 5.
- MULT 0xFFFFFFFF × 2 signed → after 5 busy cycles, hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. The same operands as MULTU → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV −7 / 2 → after 10 busy cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0.
- DIVU x / 0 with hi = 0x11, lo = 0x22 preloaded via MTHI/MTLO → busy 10 cycles; hi = 0x11, lo = 0x22 afterwards.
- req squash: MULT with req = 1 → start 0, busy stays 0, hi/lo unchanged. MTLO 0x55 with req = 1 → lo unchanged.
- In-flight vs req/new op:
  - Start DIV; in cycle 3 present MULT with req = 1 → DIV still commits at edge 10.
  - Present MTHI while busy → ignored.
  - MFLO during busy returns the pre-DIV lo.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO pair.
// A MULT/DIV result is computed in full when the operation is accepted and
// held in pend_hi/pend_lo. It is committed to HI/LO only after the
// fixed-latency busy window ends, which mimics a multi-cycle datapath.
module e_mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_rd
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // Signed divide built on magnitudes, so that 0x80000000 / -1 wraps to
  // 0x80000000 with a zero remainder instead of overflowing.
  // The result is packed as {remainder, quotient}. A zero divisor is
  // replaced by 1 only so that no X is produced; the caller then
  // suppresses the commit.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    abs_a = a[31] ? (32'd0 - a) : a;
    abs_b = b[31] ? (32'd0 - b) : b;
    if (abs_b == 32'd0) begin
      abs_b = 32'd1;
    end else begin
      abs_b = abs_b;
    end
    uq = abs_a / abs_b;
    ur = abs_a % abs_b;
    q  = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    r  = a[31] ? (32'd0 - ur) : ur;
    return {r, q};
  endfunction

  // Unsigned divide, packed as {remainder, quotient}, with the same
  // zero-divisor guard as the signed version.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    bb = (b == 32'd0) ? 32'd1 : b;
    return {a % bb, a / bb};
  endfunction

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic        is_mul_s, is_div_s, is_mthi_s, is_mtlo_s;
  logic [31:0] res_hi_s, res_lo_s;
  logic        res_ok_s;
  logic signed [63:0] mul_s_s;
  logic [63:0] mul_u_s;
  logic [63:0] div_s_s;
  logic [63:0] div_u_s;

  // Decode the operation class; unused encodings behave as NONE.
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    is_mthi_s = 1'b0;
    is_mtlo_s = 1'b0;
    case (mdu_op)
      OP_MULT, OP_MULTU: is_mul_s  = 1'b1;
      OP_DIV, OP_DIVU:   is_div_s  = 1'b1;
      OP_MTHI:           is_mthi_s = 1'b1;
      OP_MTLO:           is_mtlo_s = 1'b1;
      default:           is_mul_s  = 1'b0;
    endcase
  end

  assign start   = (is_mul_s | is_div_s) & ~req & ~busy_q;
  assign mul_s_s = $signed(rs_d) * $signed(rt_d);
  assign mul_u_s = {32'd0, rs_d} * {32'd0, rt_d};
  assign div_s_s = div_signed(rs_d, rt_d);
  assign div_u_s = div_unsigned(rs_d, rt_d);

  // Select the full result of the presented operation; a divide by zero
  // is marked as non-committing.
  always_comb begin
    res_hi_s = 32'd0;
    res_lo_s = 32'd0;
    res_ok_s = 1'b1;
    case (mdu_op)
      OP_MULT: begin
        res_hi_s = mul_s_s[63:32];
        res_lo_s = mul_s_s[31:0];
      end
      OP_MULTU: begin
        res_hi_s = mul_u_s[63:32];
        res_lo_s = mul_u_s[31:0];
      end
      OP_DIV: begin
        res_hi_s = div_s_s[63:32];
        res_lo_s = div_s_s[31:0];
        res_ok_s = (rt_d != 32'd0);
      end
      OP_DIVU: begin
        res_hi_s = div_u_s[63:32];
        res_lo_s = div_u_s[31:0];
        res_ok_s = (rt_d != 32'd0);
      end
      default: res_ok_s = 1'b1;
    endcase
  end

  // Next-state logic: accept a new op, count down and commit, or apply a
  // move-to. Each of these paths is only enabled when its preconditions
  // hold, so at most one applies on any edge.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    cnt_d     = cnt_q;
    if (start) begin
      pend_hi_d = res_hi_s;
      pend_lo_d = res_lo_s;
      pend_ok_d = res_ok_s;
      cnt_d     = is_mul_s ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
    end else if (cnt_q > 4'd1) begin
      cnt_d = cnt_q - 4'd1;
    end else if (cnt_q == 4'd1) begin
      cnt_d = 4'd0;
      if (pend_ok_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else begin
        hi_d = hi_q;
      end
    end else if (~req & ~busy_q) begin
      if (is_mthi_s) begin
        hi_d = rs_d;
      end else if (is_mtlo_s) begin
        lo_d = rs_d;
      end else begin
        hi_d = hi_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
    busy_d = (cnt_d != 4'd0);
  end

  // State registers; an asynchronous reset drops any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Move-from read port: a combinational view of the committed HI/LO.
  always_comb begin
    case (mdu_op)
      OP_MFHI: mdu_rd = hi_q;
      OP_MFLO: mdu_rd = lo_q;
      default: mdu_rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized plus directed bench for e_mdu. The reference model keeps
// HI/LO and the absolute edge number at which the pending result
// retires, and derives results with plain 64-bit arithmetic.
module tb_e_mdu;
  logic        clk;
  logic        reset;
  logic        req;
  logic [3:0]  mdu_op;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_rd;

  e_mdu dut (
    .clk(clk), .reset(reset), .req(req), .mdu_op(mdu_op),
    .rs_d(rs_d), .rt_d(rt_d), .start(start), .busy(busy),
    .hi(hi), .lo(lo), .mdu_rd(mdu_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  bit          m_pok = 1'b0;
  int          cur = 0;
  int          done_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, cur);
    end
  endtask

  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    longint r;
    longint unsigned pu;
    m_pok = 1'b1;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_phi = p[63:32];
        m_plo = p[31:0];
      end
      4'd2: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        m_phi = pu[63:32];
        m_plo = pu[31:0];
      end
      4'd3: begin
        if (b == 32'd0) begin
          m_pok = 1'b0;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_plo = q[31:0];
          m_phi = r[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          m_pok = 1'b0;
        end else begin
          m_plo = a / b;
          m_phi = a % b;
        end
      end
    endcase
  endtask

  // One clock cycle: present inputs, check the combinational and registered
  // view before the edge, advance the model at the edge, then check HI/LO.
  task automatic step(input logic [3:0] op, input logic rq, input logic [31:0] a, input logic [31:0] b);
    bit m_busy;
    bit m_start;
    logic [31:0] exp_rd;
    mdu_op = op;
    req = rq;
    rs_d = a;
    rt_d = b;
    #1;
    m_busy = (cur <= done_at);
    m_start = (op >= 4'd1 && op <= 4'd4) && !rq && !m_busy;
    exp_rd = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    chk("start", {31'd0, start}, {31'd0, m_start});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("mdu_rd", mdu_rd, exp_rd);
    @(posedge clk);
    if (cur == done_at && m_pok) begin
      m_hi = m_phi;
      m_lo = m_plo;
    end
    if (m_start) begin
      model_result(op, a, b);
      done_at = cur + ((op <= 4'd2) ? 5 : 10);
    end else if (!m_busy && !rq && op == 4'd5) begin
      m_hi = a;
    end else if (!m_busy && !rq && op == 4'd6) begin
      m_lo = a;
    end
    cur++;
    #1;
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    req = 1'b0;
    mdu_op = 4'd0;
    rs_d = 32'd0;
    rt_d = 32'd0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Reset in the middle of a MULT discards it.
    step(4'd1, 1'b0, 32'd3, 32'd4);
    step(4'd0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    done_at = -1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #2;
    reset = 1'b1;
    idle(6);
    chk("midrst_nocommit", lo, 32'd0);

    // Signed and unsigned multiply of -1 x 2.
    step(4'd1, 1'b0, 32'hFFFFFFFF, 32'd2);
    idle(5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    step(4'd2, 1'b0, 32'hFFFFFFFF, 32'd2);
    idle(5);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // Signed divides, including the overflow case.
    step(4'd3, 1'b0, 32'hFFFFFFF9, 32'd2);
    idle(10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    step(4'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    // Divide by zero keeps the preloaded HI/LO.
    step(4'd5, 1'b0, 32'h11, 32'd0);
    step(4'd6, 1'b0, 32'h22, 32'd0);
    step(4'd4, 1'b0, 32'd1234, 32'd0);
    idle(10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // Squashed MULT and MTLO have no effect.
    step(4'd1, 1'b1, 32'd5, 32'd6);
    step(4'd6, 1'b1, 32'h55, 32'd0);
    chk("sq_lo", lo, 32'h22);

    // In-flight DIV survives req, MTHI while busy, and MFLO reads old LO.
    step(4'd3, 1'b0, 32'd100, 32'd7);
    idle(2);
    step(4'd1, 1'b1, 32'd9, 32'd9);
    step(4'd5, 1'b0, 32'hDEAD, 32'd0);
    step(4'd8, 1'b0, 32'd0, 32'd0);
    chk("busy_mflo", mdu_rd, 32'h22);
    idle(5);
    chk("inflight_lo", lo, 32'd14);
    chk("inflight_hi", hi, 32'd2);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom_range(0, 10)), ($urandom_range(0, 5) == 0), pick_operand(), pick_operand());
    end
    idle(11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
